data_mem_responder: RTL



---
 rtl/data_mem_responder.sv | 96 +++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, inserts WAIT_CYCLES wait states,
// then returns a registered response that is held until the requester consumes it.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e             state_q;
    logic [3:0]         cnt_q;
    logic               we_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        mem [DEPTH_WORDS];

    logic [IDX_W-1:0]   idx;
    logic               addr_err;
    logic               access;

    assign idx = addr_q[IDX_W+1:2];

    // The full upper address is compared so out-of-range addresses never alias onto real words.
    assign addr_err  = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= DEPTH_WORDS);
    assign access    = (state_q == StWait) && (cnt_q == 4'd0);
    assign req_ready = (state_q == StIdle);

    // Memory contents survive reset; a reset on the access edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && access && we_q && !addr_err) begin
            mem[idx] <= wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt_q   <= WAIT_CNT;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= addr_err;
                        rsp_rdata <= (!we_q && !addr_err) ? mem[idx] : 32'd0;
                        state_q   <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
